// File: rtl/dm_if.sv
// Load/store bus between the datapath and the data memory.
// The datapath side is the master; the memory is the slave.
interface dm_if;
    logic [31:0] addr;
    logic [31:0] SotreData;
    logic        WriteEnable;
    logic [31:0] LoadData;

    modport master (
        output addr,
        output SotreData,
        output WriteEnable,
        input  LoadData
    );

    modport slave (
        input  addr,
        input  SotreData,
        input  WriteEnable,
        output LoadData
    );
endinterface

// File: rtl/dm.sv
// Word-addressed data memory for the single-cycle MIPS datapath.
// Reads are combinational. Writes happen on the rising clock edge. An active-low async reset clears every word.
module dm #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic clk,
    input  logic reset,
    dm_if.slave  bus
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  unused_addr_bits;

    // Byte-offset and upper address bits are dropped, so the space wraps at 4*DEPTH bytes.
    assign word_idx         = bus.addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};

    always_comb begin
        mem_d = mem_q;
        if (bus.WriteEnable) begin
            mem_d[word_idx] = bus.SotreData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.LoadData = mem_q[word_idx];

endmodule

// File: tb/tb_dm.sv
// Directed self-checking bench for dm: reset, write/read, aliasing, enable, boundaries.
module tb_dm;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    dm_if bus ();

    dm #(.DEPTH_LOG2(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        reset           = 1'b0;
        bus.WriteEnable = 1'b1;
        bus.addr        = 32'h1234_5678;
        bus.SotreData   = 32'd100;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            tests_run++;
            if (bus.LoadData !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold_neg%0d: got %h want %h", c, bus.LoadData, 32'd0);
            end
            @(posedge clk);
            #1;
            tests_run++;
            if (bus.LoadData !== 32'd0) begin
                tests_failed++;
                $display("[TB] FAIL reset_hold_pos%0d: got %h want %h", c, bus.LoadData, 32'd0);
            end
        end
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: got %h want %h", bus.LoadData, 32'd0);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_release_edge: got %h want %h", bus.LoadData, 32'd0);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.addr        = 32'h1234_5678;
        bus.SotreData   = 32'd100;
        bus.WriteEnable = 1'b1;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL no_bypass_before_edge: got %h want %h", bus.LoadData, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.WriteEnable = 1'b0;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL write_read: got %h want %h", bus.LoadData, 32'd100);
        end
    endtask

    task automatic test_isolation();
        @(negedge clk);
        bus.addr = 32'h1234_5698;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL isolation_other: got %h want %h", bus.LoadData, 32'd0);
        end
        bus.addr = 32'h1234_5678;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL isolation_back: got %h want %h", bus.LoadData, 32'd100);
        end
    endtask

    task automatic test_alias_enable();
        @(negedge clk);
        bus.addr = 32'h0000_067B;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL alias_low_bits: got %h want %h", bus.LoadData, 32'd100);
        end
        bus.addr = 32'hFFFF_F678;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL alias_high_bits: got %h want %h", bus.LoadData, 32'd100);
        end
        bus.WriteEnable = 1'b0;
        bus.SotreData   = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL write_disabled: got %h want %h", bus.LoadData, 32'd100);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
        datas = '{32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.addr        = addrs[k];
            bus.SotreData   = datas[k];
            bus.WriteEnable = 1'b1;
        end
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.addr = addrs[k];
            #1;
            tests_run++;
            if (bus.LoadData !== datas[k]) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back%0d: got %h want %h", k, bus.LoadData, datas[k]);
            end
        end
    endtask

    task automatic test_boundaries();
        @(negedge clk);
        bus.addr        = 32'h0000_0FFC;
        bus.SotreData   = 32'hA5A5_A5A5;
        bus.WriteEnable = 1'b1;
        @(negedge clk);
        bus.addr      = 32'h0000_0000;
        bus.SotreData = 32'h1111_1111;
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        bus.addr        = 32'h0000_0FFC;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("[TB] FAIL last_word: got %h want %h", bus.LoadData, 32'hA5A5_A5A5);
        end
        bus.addr = 32'h0000_0000;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'h1111_1111) begin
            tests_failed++;
            $display("[TB] FAIL first_word: got %h want %h", bus.LoadData, 32'h1111_1111);
        end
        bus.addr = 32'h1234_5678;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL no_cross_corrupt: got %h want %h", bus.LoadData, 32'd100);
        end
        // Async reset pulse mid-cycle, away from any clock edge.
        #1;
        reset = 1'b0;
        #1;
        bus.addr = 32'h0000_0FFC;
        #0;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear_last: got %h want %h", bus.LoadData, 32'd0);
        end
        bus.addr = 32'h0000_0000;
        #0;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear_first: got %h want %h", bus.LoadData, 32'd0);
        end
        reset = 1'b1;
        #1;
        bus.addr = 32'h0000_0010;
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_clear_other: got %h want %h", bus.LoadData, 32'd0);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        bus.addr        = 32'h0000_0020;
        bus.SotreData   = 32'h5555_AAAA;
        bus.WriteEnable = 1'b1;
        reset           = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_priority: got %h want %h", bus.LoadData, 32'd0);
        end
        @(negedge clk);
        bus.WriteEnable = 1'b0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.LoadData !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_priority_after: got %h want %h", bus.LoadData, 32'd0);
        end
        @(negedge clk);
        bus.WriteEnable = 1'b1;
        @(posedge clk);
        #1;
        bus.WriteEnable = 1'b0;
        tests_run++;
        if (bus.LoadData !== 32'h5555_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL first_write_after_release: got %h want %h", bus.LoadData, 32'h5555_AAAA);
        end
    endtask

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        reset           = 1'b0;
        bus.addr        = '0;
        bus.SotreData   = '0;
        bus.WriteEnable = 1'b0;
        test_reset();
        test_write_read();
        test_isolation();
        test_alias_enable();
        test_back_to_back();
        test_boundaries();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
